// File: rtl/sdp_cmux_pkg.sv
// Shared constants and FSM state type for the SDP CACC/MRDMA input mux.
package sdp_cmux_pkg;

  localparam int DW            = 256;
  localparam int PW            = DW + 2;
  localparam int LAYER_END_BIT = PW - 1;
  localparam int BATCH_END_BIT = DW;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } cmux_state_e;

endpackage

// File: rtl/sdp_cmux_skid2.sv
// Generic 2-entry skid buffer; output registered, input ready from occupancy only.
module sdp_cmux_skid2
  import sdp_cmux_pkg::*;
#(
  parameter int W = PW
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_pd,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_pd,
  output logic         out_valid,
  input  logic         out_ready
);

  logic [W-1:0] head;
  logic [W-1:0] tail;
  logic [1:0]   count;
  logic         push;
  logic         pop;

  assign in_ready  = (count < 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_pd    = head;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // head is only overwritten on push/advance so the last beat is held while empty
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      case (count)
        2'd0: begin
          if (push) begin
            head  <= in_pd;
            count <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head <= in_pd;
          end else if (push) begin
            tail  <= in_pd;
            count <= 2'd2;
          end else if (pop) begin
            count <= 2'd0;
          end
        end
        default: begin
          if (pop) begin
            head  <= tail;
            count <= 2'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/sdp_cmux_eg.sv
// SDP input mux: per-layer select of CACC or MRDMA stream, skid-buffered, with beat count and done.
module sdp_cmux_eg
  import sdp_cmux_pkg::*;
(
  input  logic          nvdla_core_clk,
  input  logic          nvdla_core_rst,
  input  logic          op_load,
  input  logic          reg2dp_flying_mode,
  input  logic [PW-1:0] cacc2sdp_pd,
  input  logic          cacc2sdp_valid,
  output logic          cacc2sdp_ready,
  input  logic [PW-1:0] sdp_mrdma2cmux_pd,
  input  logic          sdp_mrdma2cmux_valid,
  output logic          sdp_mrdma2cmux_ready,
  output logic [DW-1:0] sdp_cmux2dp_pd,
  output logic          sdp_cmux2dp_batch_end,
  output logic          sdp_cmux2dp_valid,
  input  logic          sdp_cmux2dp_ready,
  output logic          cmux_done,
  output logic [31:0]   dp2reg_cmux_beat_num
);

  cmux_state_e   state;
  cmux_state_e   state_nxt;
  logic          mode_q;
  logic [31:0]   beat_cnt;
  logic          sel_valid;
  logic [PW-1:0] sel_pd;
  logic          run_ready;
  logic          accept;
  logic          skid_in_ready;
  logic          skid_out_valid;
  logic [DW:0]   skid_out_pd;

  assign sel_valid = mode_q ? cacc2sdp_valid : sdp_mrdma2cmux_valid;
  assign sel_pd    = mode_q ? cacc2sdp_pd    : sdp_mrdma2cmux_pd;
  assign accept    = sel_valid && run_ready;

  assign cacc2sdp_ready       = run_ready && mode_q;
  assign sdp_mrdma2cmux_ready = run_ready && !mode_q;

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    run_ready = 1'b0;
    cmux_done = 1'b0;
    case (state)
      IDLE: begin
        if (op_load) state_nxt = RUN;
      end
      RUN: begin
        run_ready = skid_in_ready;
        if (accept && sel_pd[LAYER_END_BIT]) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (!skid_out_valid) begin
          cmux_done = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      mode_q   <= 1'b0;
      beat_cnt <= '0;
    end else if (state == IDLE && op_load) begin
      mode_q   <= reg2dp_flying_mode;
      beat_cnt <= '0;
    end else if (accept && beat_cnt != '1) begin
      beat_cnt <= beat_cnt + 32'd1;
    end
  end

  assign dp2reg_cmux_beat_num = beat_cnt;

  // layer_end has already been acted on at accept time, so only {batch_end, data} is buffered
  sdp_cmux_skid2 #(
    .W(DW + 1)
  ) u_skid (
    .clk       (nvdla_core_clk),
    .rst       (nvdla_core_rst),
    .in_pd     (sel_pd[DW:0]),
    .in_valid  (accept),
    .in_ready  (skid_in_ready),
    .out_pd    (skid_out_pd),
    .out_valid (skid_out_valid),
    .out_ready (sdp_cmux2dp_ready)
  );

  assign sdp_cmux2dp_valid     = skid_out_valid;
  assign sdp_cmux2dp_pd        = skid_out_pd[DW-1:0];
  assign sdp_cmux2dp_batch_end = skid_out_pd[BATCH_END_BIT];

endmodule

// File: tb/tb_sdp_cmux_eg.sv
// Randomized bench for sdp_cmux_eg against a queue-based behavioural model of the mux.
module tb_sdp_cmux_eg;
  import sdp_cmux_pkg::*;

  typedef logic [PW-1:0] pd_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          op_load;
  logic          flying_mode;
  pd_t           cacc_pd;
  logic          cacc_valid;
  logic          cacc_ready;
  pd_t           mrdma_pd;
  logic          mrdma_valid;
  logic          mrdma_ready;
  logic [DW-1:0] out_pd;
  logic          out_batch_end;
  logic          out_valid;
  logic          out_ready;
  logic          done;
  logic [31:0]   beat_num;

  always #5 clk = ~clk;

  sdp_cmux_eg dut (
    .nvdla_core_clk        (clk),
    .nvdla_core_rst        (rst),
    .op_load               (op_load),
    .reg2dp_flying_mode    (flying_mode),
    .cacc2sdp_pd           (cacc_pd),
    .cacc2sdp_valid        (cacc_valid),
    .cacc2sdp_ready        (cacc_ready),
    .sdp_mrdma2cmux_pd     (mrdma_pd),
    .sdp_mrdma2cmux_valid  (mrdma_valid),
    .sdp_mrdma2cmux_ready  (mrdma_ready),
    .sdp_cmux2dp_pd        (out_pd),
    .sdp_cmux2dp_batch_end (out_batch_end),
    .sdp_cmux2dp_valid     (out_valid),
    .sdp_cmux2dp_ready     (out_ready),
    .cmux_done             (done),
    .dp2reg_cmux_beat_num  (beat_num)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: pending source beats, the two-deep output queue, layer phase and count.
  pd_t         cq[$];
  pd_t         mq[$];
  pd_t         skq[$];
  int          phase;   // 0 waiting for op_load, 1 taking beats, 2 emptying
  bit          m_mode;
  logic [31:0] m_cnt;

  task automatic check_eq(input string tag, input pd_t act, input pd_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic pd_t mk(input bit le, input bit be, input logic [31:0] tag, input bit rnd);
    pd_t p;
    p = '0;
    if (rnd) for (int i = 0; i < DW / 32; i++) p[i*32 +: 32] = $urandom;
    p[31:0]          = tag;
    p[LAYER_END_BIT] = le;
    p[BATCH_END_BIT] = be;
    return p;
  endfunction

  task automatic step(input bit ld, input bit fm, input bit r, input bit ordy, input int gate);
    bit  cv, mv, rdy, acc, pop;
    pd_t spd;
    @(posedge clk);
    #1;
    cv = (cq.size() > 0) && ($urandom_range(99) < gate);
    mv = (mq.size() > 0) && ($urandom_range(99) < gate);
    rst         = r;
    op_load     = ld;
    flying_mode = fm;
    cacc_valid  = cv;
    cacc_pd     = cv ? cq[0] : mk(1'b1, 1'b1, $urandom, 1'b1);
    mrdma_valid = mv;
    mrdma_pd    = mv ? mq[0] : mk(1'b1, 1'b1, $urandom, 1'b1);
    out_ready   = ordy;
    @(negedge clk);
    rdy = (phase == 1) && (skq.size() < 2);
    check_eq("cacc_ready", cacc_ready, rdy && m_mode);
    check_eq("mrdma_ready", mrdma_ready, rdy && !m_mode);
    check_eq("out_valid", out_valid, skq.size() != 0);
    if (skq.size() != 0) begin
      check_eq("out_pd", out_pd, skq[0][DW-1:0]);
      check_eq("batch_end", out_batch_end, skq[0][BATCH_END_BIT]);
    end
    check_eq("done", done, (phase == 2) && (skq.size() == 0));
    check_eq("beat_num", beat_num, m_cnt);
    acc = rdy && (m_mode ? cv : mv);
    if (acc) spd = m_mode ? cq.pop_front() : mq.pop_front();
    pop = (skq.size() != 0) && ordy;
    if (r) begin
      skq.delete();
      phase  = 0;
      m_mode = 1'b0;
      m_cnt  = '0;
      return;
    end
    case (phase)
      0: if (ld) begin
        m_mode = fm;
        m_cnt  = '0;
        phase  = 1;
      end
      1: begin
        if (pop) void'(skq.pop_front());
        if (acc) begin
          skq.push_back(spd);
          if (m_cnt != 32'hffff_ffff) m_cnt = m_cnt + 32'd1;
          if (spd[LAYER_END_BIT]) phase = 2;
        end
      end
      default: begin
        if (skq.size() == 0) phase = 0;
        else if (pop) void'(skq.pop_front());
      end
    endcase
  endtask

  // ordy_pct < 0 toggles output ready every cycle.
  task automatic run_layer(input int ordy_pct, input int gate, input int ld_pct, input int rst_pct,
                           input bit chk_done);
    int cyc, dones;
    bit o, r, hit_rst;
    cyc = 0; dones = 0; hit_rst = 0;
    while (phase != 0 && cyc < 300) begin
      o = (ordy_pct < 0) ? (cyc % 2 == 0) : ($urandom_range(99) < ordy_pct);
      r = ($urandom_range(99) < rst_pct);
      hit_rst |= r;
      step($urandom_range(99) < ld_pct, 1'($urandom_range(1)), r, o, gate);
      if (done) dones++;
      cyc++;
    end
    if (chk_done && !hit_rst) check_eq("done_pulses", dones, 1);
  endtask

  function automatic void new_layer(input bit sel_cacc, input int n, input bit be_last, input bit rnd);
    cq.delete();
    mq.delete();
    for (int i = 1; i <= n; i++) begin
      if (sel_cacc) cq.push_back(mk(i == n, be_last && i == n, i, rnd));
      else          mq.push_back(mk(i == n, be_last && i == n, i, rnd));
    end
    for (int i = 0; i < 5; i++) begin
      if (sel_cacc) mq.push_back(mk(1'b1, 1'b1, 32'hdead_0000 + i, 1'b1));
      else          cq.push_back(mk(1'b1, 1'b1, 32'hbeef_0000 + i, 1'b1));
    end
  endfunction

  initial begin
    rst = 1'b1; op_load = 1'b0; flying_mode = 1'b0;
    cacc_valid = 1'b0; cacc_pd = '0; mrdma_valid = 1'b0; mrdma_pd = '0; out_ready = 1'b0;
    phase = 0; m_mode = 1'b0; m_cnt = '0;
    repeat (2) @(posedge clk);
    step(1'b0, 1'b0, 1'b1, 1'b1, 100);
    step(1'b0, 1'b0, 1'b0, 1'b1, 100);

    // MRDMA layer of 4 beats, output always ready
    new_layer(1'b0, 4, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 100);
    run_layer(100, 100, 0, 0, 1'b1);
    check_eq("t1_beat_num", beat_num, 4);

    // CACC layer while MRDMA keeps valid high
    new_layer(1'b1, 3, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1, 100);
    run_layer(100, 100, 0, 0, 1'b1);
    check_eq("t2_beat_num", beat_num, 3);

    // Output stall for 5 cycles fills the skid
    new_layer(1'b0, 6, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 100);
    repeat (5) step(1'b0, 1'b0, 1'b0, 1'b0, 100);
    check_eq("t3_stall_ready", mrdma_ready, 0);
    check_eq("t3_stall_count", beat_num, 2);
    run_layer(100, 100, 0, 0, 1'b1);
    check_eq("t3_beat_num", beat_num, 6);

    // op_load with toggled mode mid-layer is ignored
    new_layer(1'b0, 5, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 100);
    step(1'b0, 1'b0, 1'b0, 1'b1, 100);
    step(1'b1, 1'b1, 1'b0, 1'b1, 100);
    run_layer(100, 100, 0, 0, 1'b1);
    check_eq("t4_beat_num", beat_num, 5);

    // Reset while the skid holds two beats
    new_layer(1'b1, 4, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 100);
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 100);
    step(1'b0, 1'b0, 1'b1, 1'b0, 100);
    step(1'b0, 1'b0, 1'b0, 1'b1, 100);
    check_eq("t5_valid_after_rst", out_valid, 0);
    check_eq("t5_done_after_rst", done, 0);
    new_layer(1'b0, 3, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 100);
    check_eq("t5_clean_count", beat_num, 0);
    run_layer(100, 100, 0, 0, 1'b1);

    // batch_end on the layer_end beat with output ready toggling
    new_layer(1'b0, 3, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 100);
    run_layer(-1, 100, 0, 0, 1'b1);
    check_eq("t6_beat_num", beat_num, 3);

    // Random layers with random gaps, stalls, stray op_loads and occasional resets
    for (int l = 0; l < 60; l++) begin
      bit sel;
      sel = 1'($urandom_range(1));
      new_layer(sel, $urandom_range(1, 9), 1'($urandom_range(1)), 1'b1);
      repeat ($urandom_range(0, 2)) step(1'b0, 1'($urandom_range(1)), 1'b0, 1'b1, 70);
      step(1'b1, sel, 1'b0, 1'($urandom_range(1)), 70);
      run_layer(65, 75, 5, 2, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
